modn_counter: RTL and testbench
===============================

# modn_counter

Parametrised modulo-N counter; the next generation of the team's fixed mod-13 counter. Adds:
- Configurable modulus and width.
- Count enable, synchronous clear and parallel load.
- Optional down-counting.
- Registered wrap pulse for cascading stages into multi-digit timers and prescalers.

## Interface
- `WIDTH`, default 4: counter width in bits. Must satisfy 2^WIDTH >= MODULUS.
- `MODULUS`, default 13: count range is 0..MODULUS-1. Legal range is 2..2^WIDTH.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable; the count advances one step per cycle while high.
- `clr`  in  1: synchronous clear to 0.
- `load`  in  1: synchronous parallel load.
- `load_val`  in  WIDTH: value to load.
- `up_dn`  in  1: 1 = count up, 0 = count down. Present only with MODN_COUNTER_DOWN_EN.
- `count`  out  WIDTH: current count value, registered.
- `tc`  out  1: terminal-count flag, combinational from `count` and direction.
- `wrap`  out  1: registered one-cycle pulse when the counter wraps.
- `load_err`  out  1: registered one-cycle pulse when `load_val` was out of range.

## Operation
- Priority per cycle, highest first: `clr` > `load` > `en` > hold.
- `clr`: count <= 0. wrap <= 0. load_err <= 0.
- `load`:
  - If load_val <= MODULUS-1: count <= load_val, load_err <= 0.
  - Otherwise: count <= MODULUS-1, load_err <= 1.
  - wrap <= 0 in both cases.
- `en`, counting up:
  - At MODULUS-1: count <= 0, wrap <= 1.
  - Otherwise: count <= count+1.
- `en`, counting down:
  - At 0: count <= MODULUS-1, wrap <= 1.
  - Otherwise: count <= count-1.
- Hold: count unchanged. wrap <= 0. load_err <= 0.
- `tc`:
  - Up: tc = (count == MODULUS-1).
  - Down: tc = (count == 0).
  - `tc` is independent of `en`.
  - Cascading: the next stage's `en` = this stage's `en & tc`.
- Arithmetic:
  - The next-value computation is WIDTH+1 bits wide, so a true overflow never occurs.
  - For MODULUS = 2^WIDTH, the wrap compare is against all-ones.
- Direction change mid-count:
  - Takes effect on the same edge. No pipeline.
  - `tc` updates combinationally with `up_dn`.

## Timing
- Reset (rst_n low): count = 0, wrap = 0, load_err = 0, asynchronously. `tc` then follows `count` (1 if counting down).
- Reset deassertion: the first count step happens on the first rising edge with rst_n high and en high.
- Latency from `en`/`clr`/`load` to `count`: 1 cycle.
- `wrap` and `load_err` are asserted in the same cycle as the new `count` value and last exactly 1 cycle.
- Reset asserted mid-count forces count to 0 immediately, regardless of clock.
- clr and load together: the clear wins and `load_err` is not raised.
- load and en together: the load wins and no step is taken on that edge.

## Configuration
- Macro: `MODN_COUNTER_DOWN_EN`.
- Defined:
  - The `up_dn` port exists.
  - Down-count path and down-direction `tc` are compiled in.
- Undefined:
  - The `up_dn` port is absent.
  - The counter is up-only.
  - `tc` = (count == MODULUS-1).
  - Behaviour is otherwise identical to the defined case with up_dn tied to 1.

## Structure
- Shared package `modn_counter_pkg`:
  - Direction constants `DIR_UP = 1'b1`, `DIR_DN = 1'b0`.
  - Function `clog2_min(MODULUS)` for width checks.
- Elaboration assertion: 2 <= MODULUS <= 2^WIDTH.
- Sub-module `modn_step`:
  - Combinational.
  - Inputs: count, dir.
  - Outputs: next_count, wrap_next, tc.
  - Also instantiated by future prescaler blocks.
- Top-level `modn_counter` holds the registers, priority mux and load clamp.

## Test plan
All scenarios use WIDTH=4, MODULUS=13 unless stated.
- Reset: hold rst_n=0 for 2 cycles, en=1 -> count=0, wrap=0, load_err=0. Release -> count steps 1,2,… from the next edge.
- Up wrap: en=1 for 13 cycles from 0 -> count 0..12 then 0. tc=1 only while count=12. wrap=1 for exactly the single cycle after 12→0.
- Down wrap (MODN_COUNTER_DOWN_EN, up_dn=0): from 2 -> counts 1, 0, 12. tc=1 at count 0. wrap pulses on the 0→12 edge.
- Load clamp:
  - load=1, load_val=9 -> count=9, load_err=0.
  - load_val=15 -> count=12, load_err=1 for 1 cycle.
- Priority:
  - clr=1 with load=1, load_val=5, en=1 -> count=0.
  - load=1 with en=1 from count=3, load_val=7 -> count=7, no step.
- Power-of-two and async reset: with MODULUS=16 -> 15→0 with wrap=1. Drop rst_n asynchronously mid-cycle at count=6 -> count=0 before the next edge.

Source files
------------

// File: rtl/modn_counter_pkg.sv
// rtl/modn_counter_pkg.sv - shared constants and helpers for the modulo-N counter family
package modn_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Bits needed to hold 0..modulus-1; never less than one.
  function automatic int clog2_min(input int modulus);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(modulus)) w++;
    return w;
  endfunction

endpackage

// File: rtl/modn_step.sv
// rtl/modn_step.sv - combinational next-state, wrap and terminal-count logic for one modulo-N stage
module modn_step
  import modn_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_next,
  output logic             tc
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           at_last;
  logic           at_zero;

  // One extra bit: the increment of all-ones reaches MODULUS = 2^WIDTH without overflowing,
  // and the decrement borrow out of zero lands in the top bit.
  assign ext     = {1'b0, count};
  assign inc     = ext + 1'b1;
  assign dec     = ext - 1'b1;
  assign at_last = (inc == MOD_W);
  assign at_zero = dec[WIDTH];

  always_comb begin
    next_count = '0;
    wrap_next  = 1'b0;
    if (dir == DIR_UP) begin
      if (at_last) begin
        next_count = '0;
        wrap_next  = 1'b1;
      end else begin
        next_count = inc[WIDTH-1:0];
      end
    end else begin
      if (at_zero) begin
        next_count = LAST;
        wrap_next  = 1'b1;
      end else begin
        next_count = dec[WIDTH-1:0];
      end
    end
  end

  assign tc = (dir == DIR_UP) ? at_last : at_zero;

endmodule

// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - modulo-N counter with clear, clamped load, enable and wrap pulse
// Define MODN_COUNTER_DOWN_EN to add the up_dn port and down counting.
module modn_counter
  import modn_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODN_COUNTER_DOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || clog2_min(MODULUS) > WIDTH) begin : g_bad_params
    $error("modn_counter: MODULUS must lie in 2..2^WIDTH");
  end

  logic             dir;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             load_over;

`ifdef MODN_COUNTER_DOWN_EN
  assign dir = up_dn;
`else
  assign dir = DIR_UP;
`endif

  modn_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .count      (count),
    .dir        (dir),
    .next_count (step_next),
    .wrap_next  (step_wrap),
    .tc         (tc)
  );

  assign load_over = ({1'b0, load_val} >= MOD_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      // Out-of-range loads saturate to the top of the range and flag it.
      count    <= load_over ? LAST : load_val;
      wrap     <= 1'b0;
      load_err <= load_over;
    end else if (en) begin
      count    <= step_next;
      wrap     <= step_wrap;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// tb/tb_modn_counter.sv - self-checking bench for modn_counter (MODULUS 13 and 16 side by side)
module tb_modn_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, clr, load;
  logic [3:0] load_val;
`ifdef MODN_COUNTER_DOWN_EN
  logic       up_dn;
`endif

  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, err_a, err_b;

  modn_counter #(.WIDTH(4), .MODULUS(13)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef MODN_COUNTER_DOWN_EN
    .up_dn(up_dn),
`endif
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  modn_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef MODN_COUNTER_DOWN_EN
    .up_dn(up_dn),
`endif
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain modular arithmetic per modulus.
  int mods[2] = '{13, 16};
  int m_cnt[2];
  bit m_wrap[2];
  bit m_err[2];

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic [3:0] val;
    int         exp_count;
    logic       exp_tc;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  vec_t tbl[13];

  function automatic bit dir_now();
`ifdef MODN_COUNTER_DOWN_EN
    return up_dn;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_tc(int k);
    return dir_now() ? (m_cnt[k] == mods[k] - 1) : (m_cnt[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_cnt[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
      end else if (load) begin
        m_wrap[k] = 0;
        if (int'(load_val) < mods[k]) begin
          m_cnt[k] = int'(load_val); m_err[k] = 0;
        end else begin
          m_cnt[k] = mods[k] - 1; m_err[k] = 1;
        end
      end else if (en) begin
        m_err[k] = 0;
        if (dir_now()) begin
          m_wrap[k] = (m_cnt[k] == mods[k] - 1);
          m_cnt[k]  = (m_cnt[k] + 1) % mods[k];
        end else begin
          m_wrap[k] = (m_cnt[k] == 0);
          m_cnt[k]  = (m_cnt[k] + mods[k] - 1) % mods[k];
        end
      end else begin
        m_wrap[k] = 0; m_err[k] = 0;
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " a.count"}, int'(count_a), m_cnt[0]);
    chk({tag, " a.tc"},    int'(tc_a),    int'(exp_tc(0)));
    chk({tag, " a.wrap"},  int'(wrap_a),  int'(m_wrap[0]));
    chk({tag, " a.err"},   int'(err_a),   int'(m_err[0]));
    chk({tag, " b.count"}, int'(count_b), m_cnt[1]);
    chk({tag, " b.tc"},    int'(tc_b),    int'(exp_tc(1)));
    chk({tag, " b.wrap"},  int'(wrap_b),  int'(m_wrap[1]));
    chk({tag, " b.err"},   int'(err_b),   int'(m_err[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_in(logic c, logic l, logic e, logic [3:0] v);
    clr = c; load = l; en = e; load_val = v;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd9,  9,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd15, 12, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  12, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd0,  0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'd5,  0,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'd3,  3,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'd7,  7,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd15, 0,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd0,  1,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'd12, 12, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 4'd0,  0,  1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
`ifdef MODN_COUNTER_DOWN_EN
    up_dn = 1'b1;
`endif
    set_in(1'b0, 1'b0, 1'b1, 4'd0);
    model_reset();

    // Reset held for two edges with en high.
    repeat (2) @(posedge clk);
    #1;
    chk("reset count_a", int'(count_a), 0);
    chk("reset count_b", int'(count_b), 0);
    chk("reset wrap_a",  int'(wrap_a),  0);
    chk("reset err_a",   int'(err_a),   0);
    chk("reset tc_a",    int'(tc_a),    0);
    rst_n = 1'b1;
    cycle();
    chk("release step1", int'(count_a), 1);
    check_model("release1");
    cycle();
    chk("release step2", int'(count_a), 2);
    check_model("release2");

    set_in(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    check_model("clr");

    foreach (tbl[i]) begin
      set_in(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].val);
      cycle();
      chk($sformatf("tbl%0d count", i), int'(count_a), tbl[i].exp_count);
      chk($sformatf("tbl%0d tc", i),    int'(tc_a),    int'(tbl[i].exp_tc));
      chk($sformatf("tbl%0d wrap", i),  int'(wrap_a),  int'(tbl[i].exp_wrap));
      chk($sformatf("tbl%0d err", i),   int'(err_a),   int'(tbl[i].exp_err));
      check_model($sformatf("tbl%0d", i));
    end

    // Full up wrap for both moduli from zero.
    set_in(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      chk($sformatf("upwrap%0d a.count", i), int'(count_a), i % 13);
      chk($sformatf("upwrap%0d a.wrap", i),  int'(wrap_a),  int'(i == 13));
      chk($sformatf("upwrap%0d b.count", i), int'(count_b), i % 16);
      chk($sformatf("upwrap%0d b.wrap", i),  int'(wrap_b),  int'(i == 16));
      check_model($sformatf("upwrap%0d", i));
    end

`ifdef MODN_COUNTER_DOWN_EN
    // Down: 2 -> 1 -> 0 -> 12, direction change takes effect on the same edge.
    set_in(1'b0, 1'b1, 1'b0, 4'd2);
    cycle();
    up_dn = 1'b0;
    #1;
    chk("down tc at 2", int'(tc_a), 0);
    set_in(1'b0, 1'b0, 1'b1, 4'd0);
    cycle();
    chk("down step1", int'(count_a), 1);
    check_model("down1");
    cycle();
    chk("down step0", int'(count_a), 0);
    chk("down tc0",   int'(tc_a),    1);
    check_model("down2");
    cycle();
    chk("down wrap count", int'(count_a), 12);
    chk("down wrap pulse", int'(wrap_a),  1);
    check_model("down3");
    up_dn = 1'b1;
    #1;
    chk("dir flip tc", int'(tc_a), 1);
`endif

    // Async reset mid-cycle at count 6.
    set_in(1'b1, 1'b0, 1'b0, 4'd0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (6) cycle();
    en = 1'b0;
    chk("pre-async count", int'(count_a), 6);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async count_a", int'(count_a), 0);
    chk("async count_b", int'(count_b), 0);
    chk("async wrap_a",  int'(wrap_a),  0);
    chk("async err_a",   int'(err_a),   0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_model("after async");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0, 4'($urandom));
`ifdef MODN_COUNTER_DOWN_EN
      up_dn = 1'($urandom);
`endif
      cycle();
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
